// File: rtl/triangle_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : triangle_pkg
//  Purpose  : State encoding, shape codes and width helpers for triangle_seq_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
package triangle_pkg;

    typedef logic [3:0] state_t;

    localparam state_t S_IDLE   = 4'd0;
    localparam state_t S_CHK_AB = 4'd1;
    localparam state_t S_CHK_BC = 4'd2;
    localparam state_t S_CHK_CA = 4'd3;
    localparam state_t S_SQ_A   = 4'd4;
    localparam state_t S_SQ_B   = 4'd5;
    localparam state_t S_SQ_C   = 4'd6;
    localparam state_t S_RCHK   = 4'd7;
    localparam state_t S_DONE   = 4'd8;

    localparam logic [1:0] KIND_NONE    = 2'd0;
    localparam logic [1:0] KIND_SCALENE = 2'd1;
    localparam logic [1:0] KIND_ISO     = 2'd2;
    localparam logic [1:0] KIND_EQUI    = 2'd3;

    // Three W-bit squares summed need two guard bits beyond 2W.
    function automatic int sq_sum_width(input int w);
        return 2 * w + 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tri_arith_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tri_arith_unit
//  Purpose  : Shared adder/comparator, squarer and sum-of-squares compare,
//             with operands selected by the controller state.
//  Revision : 1.0  initial release
// ============================================================================
module tri_arith_unit
    import triangle_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [3:0]     state,
    input  logic [W-1:0]   ra,
    input  logic [W-1:0]   rb,
    input  logic [W-1:0]   rc,
    input  logic [2*W-1:0] sa,
    input  logic [2*W-1:0] sb,
    input  logic [2*W-1:0] sc,
    input  logic [2*W-1:0] msq,
    output logic           ineq_pass,
    output logic [2*W-1:0] sq,
    output logic           right_hit
);

    localparam int SW = sq_sum_width(W);

    logic [W-1:0]  w_add_x;
    logic [W-1:0]  w_add_y;
    logic [W-1:0]  w_cmp_z;
    logic [W-1:0]  w_mul_x;
    logic [W:0]    w_sum;
    logic [SW-1:0] w_sq_sum;
    logic [SW-1:0] w_twice_max;

    always_comb begin
        w_add_x = ra;
        w_add_y = rb;
        w_cmp_z = rc;
        w_mul_x = ra;
        case (state)
            S_CHK_BC: begin
                w_add_x = rb;
                w_add_y = rc;
                w_cmp_z = ra;
            end
            S_CHK_CA: begin
                w_add_x = rc;
                w_add_y = ra;
                w_cmp_z = rb;
            end
            S_SQ_B:  w_mul_x = rb;
            S_SQ_C:  w_mul_x = rc;
            default: ;
        endcase
    end

    // Zero-extended sum cannot overflow; strict compare rejects degenerate sides.
    assign w_sum     = {1'b0, w_add_x} + {1'b0, w_add_y};
    assign ineq_pass = (w_sum > {1'b0, w_cmp_z});

    assign sq = {{W{1'b0}}, w_mul_x} * {{W{1'b0}}, w_mul_x};

    // The largest square belongs to the hypotenuse, so a^2+b^2+c^2 == 2*max^2.
    assign w_sq_sum    = SW'(sa) + SW'(sb) + SW'(sc);
    assign w_twice_max = SW'({msq, 1'b0});
    assign right_hit   = (w_sq_sum == w_twice_max);

endmodule
`default_nettype wire

// File: rtl/triangle_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : triangle_seq_ctrl
//  Purpose  : Sequential triangle classifier with handshaked input and result.
//  Revision : 1.0  initial release
// ============================================================================
module triangle_seq_ctrl
    import triangle_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out,
    output logic [1:0]   kind,
    output logic         right,
    output logic         busy
);

    state_t         r_state;
    state_t         w_next;
    logic [W-1:0]   r_ra;
    logic [W-1:0]   r_rb;
    logic [W-1:0]   r_rc;
    logic [2*W-1:0] r_sa;
    logic [2*W-1:0] r_sb;
    logic [2*W-1:0] r_sc;
    logic [2*W-1:0] r_msq;
    logic           r_out;
    logic [1:0]     r_kind;
    logic           r_right;

    logic           w_pass;
    logic [2*W-1:0] w_sq;
    logic           w_right_hit;
    logic [1:0]     w_kind;
    logic           w_accept;

    tri_arith_unit #(.W(W)) u_arith (
        .state     (r_state),
        .ra        (r_ra),
        .rb        (r_rb),
        .rc        (r_rc),
        .sa        (r_sa),
        .sb        (r_sb),
        .sc        (r_sc),
        .msq       (r_msq),
        .ineq_pass (w_pass),
        .sq        (w_sq),
        .right_hit (w_right_hit)
    );

    assign w_accept = in_valid && (r_state == S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (in_valid)  w_next = S_CHK_AB;
            S_CHK_AB: w_next = w_pass ? S_CHK_BC : S_DONE;
            S_CHK_BC: w_next = w_pass ? S_CHK_CA : S_DONE;
            S_CHK_CA: w_next = w_pass ? S_SQ_A   : S_DONE;
            S_SQ_A:   w_next = S_SQ_B;
            S_SQ_B:   w_next = S_SQ_C;
            S_SQ_C:   w_next = S_RCHK;
            S_RCHK:   w_next = S_DONE;
            S_DONE:   if (out_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == S_IDLE);
        out_valid = (r_state == S_DONE);
        busy      = (r_state != S_IDLE);
    end

    always_comb begin
        w_kind = KIND_SCALENE;
        if ((r_ra == r_rb) && (r_rb == r_rc))
            w_kind = KIND_EQUI;
        else if ((r_ra == r_rb) || (r_rb == r_rc) || (r_rc == r_ra))
            w_kind = KIND_ISO;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ra    <= '0;
            r_rb    <= '0;
            r_rc    <= '0;
            r_sa    <= '0;
            r_sb    <= '0;
            r_sc    <= '0;
            r_msq   <= '0;
            r_out   <= 1'b0;
            r_kind  <= KIND_NONE;
            r_right <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_ra <= a;
                        r_rb <= b;
                        r_rc <= c;
                    end
                end
                S_CHK_AB, S_CHK_BC, S_CHK_CA: begin
                    if (!w_pass) begin
                        r_out   <= 1'b0;
                        r_kind  <= KIND_NONE;
                        r_right <= 1'b0;
                    end
                end
                S_SQ_A: begin
                    r_sa  <= w_sq;
                    r_msq <= w_sq;
                end
                S_SQ_B: begin
                    r_sb <= w_sq;
                    if (w_sq > r_msq) r_msq <= w_sq;
                end
                S_SQ_C: begin
                    r_sc <= w_sq;
                    if (w_sq > r_msq) r_msq <= w_sq;
                end
                S_RCHK: begin
                    r_out   <= 1'b1;
                    r_kind  <= w_kind;
                    r_right <= w_right_hit;
                end
                default: ;
            endcase
        end
    end

    assign out   = r_out;
    assign kind  = r_kind;
    assign right = r_right;

endmodule
`default_nettype wire

// File: tb/tb_triangle_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_triangle_seq_ctrl
//  Purpose  : Directed self-checking bench for triangle_seq_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
module tb_triangle_seq_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] c = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic         out;
    logic [1:0]   kind;
    logic         right;
    logic         busy;

    int n_checks = 0;
    int n_fails  = 0;

    triangle_seq_ctrl #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .kind      (kind),
        .right     (right),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Present a job, count edges from the accept edge until out_valid, check result.
    task automatic run_job(input logic [W-1:0] ta, input logic [W-1:0] tb,
                           input logic [W-1:0] tc, input int exp_lat,
                           input logic exp_out, input logic [1:0] exp_kind,
                           input logic exp_right, input string name);
        int lat;
        int wait_n;
        wait_n = 0;
        while (!in_ready && wait_n < 20) begin
            @(posedge clk); #1;
            wait_n++;
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL %s in_ready timeout: got %b want 1", name, in_ready);
        end
        a = ta; b = tb; c = tc; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = '1; b = '1; c = '1;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        n_checks++;
        if (lat !== exp_lat) begin
            n_fails++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
        end
        n_checks++;
        if ({out, kind, right} !== {exp_out, exp_kind, exp_right}) begin
            n_fails++;
            $display("FAIL %s result out/kind/right: got %b/%0d/%b want %b/%0d/%b",
                     name, out, kind, right, exp_out, exp_kind, exp_right);
        end
    endtask

    // With out_ready high, the edge after DONE entry must land in IDLE.
    task automatic expect_idle_next(input string name);
        @(posedge clk); #1;
        n_checks++;
        if ({out_valid, busy, in_ready} !== 3'b001) begin
            n_fails++;
            $display("FAIL %s return to idle: got valid/busy/ready %b%b%b want 001",
                     name, out_valid, busy, in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_checks++;
        if ({out_valid, busy, out, kind, right} !== 6'b0) begin
            n_fails++;
            $display("FAIL reset outputs: got %b%b%b%b%b want 000000",
                     out_valid, busy, out, kind, right);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL reset in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_classify();
        run_job(8'd3,   8'd4,   8'd5,   7, 1'b1, 2'd1, 1'b1, "t345");
        expect_idle_next("t345");
        run_job(8'd1,   8'd127, 8'd255, 1, 1'b0, 2'd0, 1'b0, "fail_ab");
        expect_idle_next("fail_ab");
        run_job(8'd10,  8'd2,   8'd3,   2, 1'b0, 2'd0, 1'b0, "fail_bc");
        expect_idle_next("fail_bc");
        run_job(8'd0,   8'd128, 8'd127, 3, 1'b0, 2'd0, 1'b0, "zero_side");
        expect_idle_next("zero_side");
        run_job(8'd255, 8'd128, 8'd128, 7, 1'b1, 2'd2, 1'b0, "iso_wide");
        expect_idle_next("iso_wide");
        run_job(8'd1,   8'd1,   8'd1,   7, 1'b1, 2'd3, 1'b0, "equi");
        expect_idle_next("equi");
        run_job(8'd10,  8'd100, 8'd255, 1, 1'b0, 2'd0, 1'b0, "fail_ab2");
        expect_idle_next("fail_ab2");
        run_job(8'd2,   8'd3,   8'd5,   1, 1'b0, 2'd0, 1'b0, "degenerate");
        expect_idle_next("degenerate");
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        run_job(8'd3, 8'd4, 8'd5, 7, 1'b1, 2'd1, 1'b1, "bp_job");
        a = 8'd9; b = 8'd9; c = 8'd9; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({out_valid, in_ready, busy, out, kind, right} !== 7'b1011011) begin
                n_fails++;
                $display("FAIL bp_hold cycle %0d: got v/r/b/o/k/rt %b%b%b%b%0d%b want 1 0 1 1 1 1",
                         i, out_valid, in_ready, busy, out, kind, right);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        expect_idle_next("bp_release");
        n_checks++;
        if ({out, kind, right} !== 4'b1011) begin
            n_fails++;
            $display("FAIL bp_result_hold: got %b/%0d/%b want 1/1/1", out, kind, right);
        end
        run_job(8'd6, 8'd8, 8'd10, 7, 1'b1, 2'd1, 1'b1, "bp_next");
        expect_idle_next("bp_next");
    endtask

    task automatic test_reset_midjob();
        a = 8'd3; b = 8'd4; c = 8'd5; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        // Edges e1..e4 leave the block in SQ_B.
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, busy, out, kind, right} !== 6'b0) begin
            n_fails++;
            $display("FAIL midjob_reset: got v/b/o/k/r %b%b%b%0d%b want 0 0 0 0 0",
                     out_valid, busy, out, kind, right);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_job(8'd5, 8'd12, 8'd13, 7, 1'b1, 2'd1, 1'b1, "after_reset");
        expect_idle_next("after_reset");
    endtask

    task automatic test_back_to_back();
        run_job(8'd5, 8'd3, 8'd4, 7, 1'b1, 2'd1, 1'b1, "perm_534");
        expect_idle_next("perm_534");
        run_job(8'd4, 8'd5, 8'd3, 7, 1'b1, 2'd1, 1'b1, "perm_453");
        expect_idle_next("perm_453");
        run_job(8'd5, 8'd5, 8'd8, 7, 1'b1, 2'd2, 1'b0, "iso_58");
    endtask

    initial begin
        test_reset();
        test_classify();
        test_backpressure();
        test_reset_midjob();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
